mem_stage_ctrl: RTL and testbench

//  - MEM pipeline stage: consumes the EX/MEM register outputs, performs the data-memory access and

---
 rtl/mem_stage_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage. Performs the data-memory access for loads and
// stores from the EX/MEM register and registers the MEM/WB payload. Memory accesses
// take MEM_LAT cycles and hold the upstream stages through `stall`. Non-memory
// instructions pass through in one cycle.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned loads and
// stores are trapped and reported on misalign_err instead of accessing memory.
module mem_stage_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8,
  parameter int MEM_LAT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memtoReg_in,
  input  logic        regWrite_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  reg_dst_in,
  output logic        stall,
  output logic        memtoReg_out,
  output logic        regWrite_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  reg_dst_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Counter value of the final (completing) access cycle.
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  // Copy of the request taken when a multi-cycle access starts. The EX/MEM
  // inputs may change while the access is in flight.
  logic        lat_write_reg;
  logic        lat_memtoreg_reg;
  logic        lat_regwrite_reg;
  logic [31:0] lat_alu_reg;
  logic [31:0] lat_wdata_reg;
  logic [4:0]  lat_dst_reg;

  // The request that the access logic works on this cycle.
  // It comes from the live inputs in IDLE and from the latched copy in ACCESS.
  logic              acc_write;
  logic              acc_memtoreg;
  logic              acc_regwrite;
  logic [31:0]       acc_alu;
  logic [31:0]       acc_wdata;
  logic [4:0]        acc_dst;
  logic [ADDR_W-1:0] acc_idx;

  logic req;
  logic misaligned;
  logic start;
  logic complete;
  logic pass;
  logic ram_we;

  logic [31:0] ram [DEPTH_WORDS];

  assign req = memRead_in | memWrite_in;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = req && (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Select the live request in IDLE and the latched request during ACCESS.
  always_comb begin
    acc_write    = memWrite_in;
    acc_memtoreg = memtoReg_in;
    acc_regwrite = regWrite_in;
    acc_alu      = alu_result_in;
    acc_wdata    = write_data_in;
    acc_dst      = reg_dst_in;
    if (state_reg == ACCESS) begin
      acc_write    = lat_write_reg;
      acc_memtoreg = lat_memtoreg_reg;
      acc_regwrite = lat_regwrite_reg;
      acc_alu      = lat_alu_reg;
      acc_wdata    = lat_wdata_reg;
      acc_dst      = lat_dst_reg;
    end
    // Only the word index is used. Address bits above the RAM size wrap around.
    acc_idx = acc_alu[ADDR_W+1:2];
  end

  // Next-state, latency counter, stall and per-edge action decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    pass       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req && !misaligned) begin
          if (MEM_LAT == 1) begin
            complete = 1'b1;
          end else begin
            start      = 1'b1;
            stall      = 1'b1;
            state_next = ACCESS;
            cnt_next   = 4'd1;
          end
        end else begin
          pass = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_reg == LAST_CNT) begin
          complete   = 1'b1;
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
    // Stall must drop in the same cycle that reset is asserted.
    if (reset) begin
      stall = 1'b0;
    end
  end

  // A store commits only at its completing edge. A store interrupted by reset is lost.
  assign ram_we = complete & acc_write & ~reset;

  // FSM state and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request when a multi-cycle access begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write_reg    <= 1'b0;
      lat_memtoreg_reg <= 1'b0;
      lat_regwrite_reg <= 1'b0;
      lat_alu_reg      <= 32'd0;
      lat_wdata_reg    <= 32'd0;
      lat_dst_reg      <= 5'd0;
    end else if (start) begin
      lat_write_reg    <= memWrite_in;
      lat_memtoreg_reg <= memtoReg_in;
      lat_regwrite_reg <= regWrite_in;
      lat_alu_reg      <= alu_result_in;
      lat_wdata_reg    <= write_data_in;
      lat_dst_reg      <= reg_dst_in;
    end
  end

  // Data RAM write port. The contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

  // MEM/WB payload. Each edge does one of three things:
  //  - on completion, outputs take the access result;
  //  - on pass-through, outputs take the live inputs;
  //  - on any other edge, outputs carry a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memtoReg_out   <= 1'b0;
      regWrite_out   <= 1'b0;
      read_data_out  <= 32'd0;
      alu_result_out <= 32'd0;
      reg_dst_out    <= 5'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_err   <= 1'b0;
`endif
    end else if (complete) begin
      memtoReg_out   <= acc_memtoreg;
      regWrite_out   <= acc_regwrite;
      read_data_out  <= acc_write ? 32'd0 : ram[acc_idx];
      alu_result_out <= acc_alu;
      reg_dst_out    <= acc_dst;
`ifdef MISALIGN_TRAP_EN
      misalign_err   <= 1'b0;
`endif
    end else if (pass) begin
      memtoReg_out   <= memtoReg_in;
      regWrite_out   <= regWrite_in & ~misaligned;
      read_data_out  <= 32'd0;
      alu_result_out <= alu_result_in;
      reg_dst_out    <= reg_dst_in;
`ifdef MISALIGN_TRAP_EN
      misalign_err   <= misaligned;
`endif
    end else begin
      memtoReg_out   <= 1'b0;
      regWrite_out   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_err   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: self-checking bench for mem_stage_ctrl.
// The bench acts as the upstream pipeline: it holds each instruction while stall is
// high and scrambles the inputs once an access is in flight. Results are compared
// against a word-array memory model and a latency rule for each transaction.
module tb_mem_stage_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_in, memWrite_in, memtoReg_in, regWrite_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  reg_dst_in;
  logic        stall, memtoReg_out, regWrite_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  reg_dst_out;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] hold_alu, hold_rdata;
  logic [4:0]  hold_dst;

  mem_stage_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (AW),
    .MEM_LAT    (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .memRead_in    (memRead_in),
    .memWrite_in   (memWrite_in),
    .memtoReg_in   (memtoReg_in),
    .regWrite_in   (regWrite_in),
    .alu_result_in (alu_result_in),
    .write_data_in (write_data_in),
    .reg_dst_in    (reg_dst_in),
    .stall         (stall),
    .memtoReg_out  (memtoReg_out),
    .regWrite_out  (regWrite_out),
    .read_data_out (read_data_out),
    .alu_result_out(alu_result_out),
    .reg_dst_out   (reg_dst_out)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
    memRead_in    = rd;
    memWrite_in   = wr;
    memtoReg_in   = m2r;
    regWrite_in   = rw;
    alu_result_in = alu;
    write_data_in = wd;
    reg_dst_in    = dst;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic drive_garbage();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom, $urandom, 5'($urandom));
  endtask

  // Present one instruction (starting #1 after a rising edge) and follow it to completion.
  task automatic do_txn(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
    int          idx;
    int          stalls;
    int          want_stalls;
    bit          is_mem;
    bit          mis;
    logic [31:0] want_rdata;
    logic        want_rw;
    is_mem = rd | wr;
    mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = is_mem && (alu[1:0] != 2'b00);
`endif
    idx         = int'((alu / 4) % DEPTH);
    want_stalls = (is_mem && !mis) ? LAT - 1 : 0;
    drive(rd, wr, m2r, rw, alu, wd, dst);
    stalls = 0;
    @(negedge clk);
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk);
      #1 drive_garbage();
      @(negedge clk);
      check("bubble_regwrite", 32'(regWrite_out), 32'd0);
      check("bubble_memtoreg", 32'(memtoReg_out), 32'd0);
      check("bubble_alu_hold", alu_result_out, hold_alu);
      check("bubble_dst_hold", 32'(reg_dst_out), 32'(hold_dst));
      check("bubble_rdata_hold", read_data_out, hold_rdata);
`ifdef MISALIGN_TRAP_EN
      check("bubble_misalign", 32'(misalign_err), 32'd0);
`endif
    end
    check("stall_cycles", 32'(stalls), 32'(want_stalls));
    @(posedge clk);
    #1;
    if (mis) begin
      want_rw    = 1'b0;
      want_rdata = 32'd0;
    end else if (is_mem && wr) begin
      model_mem[idx] = wd;
      want_rw    = rw;
      want_rdata = 32'd0;
    end else if (is_mem) begin
      want_rw    = rw;
      want_rdata = model_mem[idx];
    end else begin
      want_rw    = rw;
      want_rdata = 32'd0;
    end
    check("out_regwrite", 32'(regWrite_out), 32'(want_rw));
    check("out_memtoreg", 32'(memtoReg_out), 32'(m2r));
    check("out_alu", alu_result_out, alu);
    check("out_dst", 32'(reg_dst_out), 32'(dst));
    check("out_rdata", read_data_out, want_rdata);
`ifdef MISALIGN_TRAP_EN
    check("out_misalign", 32'(misalign_err), 32'(mis));
`endif
    hold_alu   = alu;
    hold_dst   = dst;
    hold_rdata = want_rdata;
    txn_no++;
    $display("TXN %0d rd=%0b wr=%0b addr=%08h wdata=%08h dst=%0d stalls=%0d rdata=%08h",
             txn_no, rd, wr, alu, wd, dst, stalls, read_data_out);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_regwrite"}, 32'(regWrite_out), 32'd0);
    check({tag, "_memtoreg"}, 32'(memtoReg_out), 32'd0);
    check({tag, "_rdata"}, read_data_out, 32'd0);
    check({tag, "_alu"}, alu_result_out, 32'd0);
    check({tag, "_dst"}, 32'(reg_dst_out), 32'd0);
`ifdef MISALIGN_TRAP_EN
    check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
`endif
  endtask

  initial begin
    int          kind;
    int          widx;
    logic [31:0] addr;

    reset = 1'b1;
    drive_idle();
    hold_alu   = 32'd0;
    hold_dst   = 5'd0;
    hold_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Give the words that later loads use known contents.
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4), $urandom, 5'd0);
    end

    // ALU pass-through.
    do_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'd0, 5'd5);

    // Store, then load back from the same address.
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'd0, 5'd9);

    // Address wrap: 0x400 and 0x000 hit the same word.
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'hA5A5_A5A5, 5'd0);
    do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'd0, 5'd10);

    // Read and write together behave as a store.
    do_txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0018, 32'h1357_9BDF, 5'd11);
    do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0018, 32'd0, 5'd12);

`ifdef MISALIGN_TRAP_EN
    do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'd0, 5'd13);
`endif

    // Reset in the middle of a store: the store must be lost.
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h1111_2222, 5'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0001, 5'd0);
    @(negedge clk);
    check("rst_pre_stall", 32'(stall), 32'(LAT > 1));
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    #1 check_all_zero("rst_held");
    reset = 1'b0;
    drive_idle();
    if (LAT == 1) begin
      model_mem[8] = 32'h0000_0001;
    end
    hold_alu   = 32'd0;
    hold_dst   = 5'd0;
    hold_rdata = 32'd0;
    do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'd0, 5'd14);

    // Random mix of ALU ops, loads, stores and read+write requests.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 3));
      widx = int'($urandom_range(0, 15));
      addr = ($urandom & 32'hFFFF_FC00) | 32'(widx * 4) | 32'($urandom_range(0, 3));
      case (kind)
        0: do_txn(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
        1: do_txn(1'b1, 1'b0, 1'($urandom), 1'($urandom), addr, $urandom, 5'($urandom));
        2: do_txn(1'b0, 1'b1, 1'($urandom), 1'($urandom), addr, $urandom, 5'($urandom));
        default: do_txn(1'b1, 1'b1, 1'($urandom), 1'($urandom), addr, $urandom, 5'($urandom));
      endcase
    end

    drive_idle();
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
